// File: rtl/div_ctrl.sv
// div_ctrl: signed-divide front end for an unsigned multi-cycle divider, with divide-by-zero, overflow and timeout handling
module div_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_quotient,
  output logic [31:0] out_remainder,
  output logic [2:0]  out_flags
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic [2:0] flg_q, flg_d;
  logic qn_q, qn_d, rn_q, rn_d, seen_q, seen_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic xfer, fin, tout, ovf;
  assign xfer = in_valid & in_ready;
  assign fin = seen_q & ~div_busy;
  assign tout = cnt_q == CW'(TIMEOUT - 1);
  // only -2^31 / -1 yields a positive magnitude with bit 31 set
  assign ovf = div_quotient[31] & ~qn_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      flg_q <= '0;
      qn_q <= 1'b0;
      rn_q <= 1'b0;
      seen_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      flg_q <= flg_d;
      qn_q <= qn_d;
      rn_q <= rn_d;
      seen_q <= seen_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = (in_divisor == '0) ? DONE : START;
      START:   state_d = WAIT;
      WAIT:    if (fin || tout) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == IDLE;
    div_start = state_q == START;
    out_valid = state_q == DONE;
  end
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    flg_d = flg_q;
    qn_d = qn_q;
    rn_d = rn_q;
    seen_d = seen_q;
    cnt_d = cnt_q;
    if (xfer) begin
      dvd_d = in_dividend[31] ? -in_dividend : in_dividend;
      dvs_d = in_divisor[31] ? -in_divisor : in_divisor;
      qn_d = in_dividend[31] ^ in_divisor[31];
      rn_d = in_dividend[31];
      seen_d = 1'b0;
      cnt_d = '0;
      if (in_divisor == '0) begin
        quo_d = in_dividend[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        rem_d = in_dividend;
        flg_d = 3'b001;
      end
    end else if (state_q == WAIT) begin
      seen_d = seen_q | div_busy;
      cnt_d = cnt_q + 1'b1;
      if (fin) begin
        quo_d = ovf ? 32'h7FFF_FFFF : (qn_q ? -div_quotient : div_quotient);
        rem_d = rn_q ? -div_remainder : div_remainder;
        flg_d = {1'b0, ovf, 1'b0};
      end else if (tout) begin
        quo_d = '0;
        rem_d = '0;
        flg_d = 3'b100;
      end
    end
  end
  assign div_dividend = dvd_q;
  assign div_divisor = dvs_q;
  assign out_quotient = quo_q;
  assign out_remainder = rem_q;
  assign out_flags = flg_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed vectors against div_ctrl with a 32-cycle unsigned divider model
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_dividend = '0;
  logic [31:0] in_divisor = '0;
  logic in_ready, div_start, div_busy, out_valid;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder, out_quotient, out_remainder;
  logic [2:0] out_flags;
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int bcnt = 0;
  logic tie0 = 1'b0;
  logic [31:0] mq = '0;
  logic [31:0] mr = '0;

  always #5 clk = ~clk;

  div_ctrl #(.TIMEOUT(40)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_flags(out_flags)
  );

  // busy for the 32 cycles after the start edge; tie0 models a dead divider
  assign div_busy = bcnt != 0;
  assign div_quotient = mq;
  assign div_remainder = mr;
  always @(posedge clk) begin
    if (div_start) starts <= starts + 1;
    if (div_start && !tie0) begin
      bcnt <= 32;
      mq <= (div_divisor != 0) ? div_dividend / div_divisor : 32'h0;
      mr <= (div_divisor != 0) ? div_dividend % div_divisor : 32'h0;
    end else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                     input logic [31:0] er, input logic [2:0] ef, input int lat, input int nst,
                     input bit hold);
    int n;
    int s0;
    logic ok;
    @(negedge clk);
    in_dividend = a;
    in_divisor = b;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 1);
    s0 = starts;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk("latency", 32'(n), 32'(lat));
    chk("quotient", out_quotient, eq);
    chk("remainder", out_remainder, er);
    chk("flags", 32'(out_flags), 32'(ef));
    chk("start_pulses", 32'(starts - s0), 32'(nst));
    if (hold) begin
      ok = 1'b1;
      in_valid = 1'b1;
      repeat (10) begin
        @(negedge clk);
        ok &= out_valid && !in_ready && out_quotient == eq && out_remainder == er && out_flags == ef;
      end
      in_valid = 1'b0;
      chk("hold_stable", 32'(ok), 1);
      chk("hold_no_start", 32'(starts - s0), 32'(nst));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("in_ready_after", 32'(in_ready), 1);
    chk("out_valid_after", 32'(out_valid), 0);
  endtask

  initial begin
    logic ov;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_flags", 32'(out_flags), 0);
    chk("rst_quotient", out_quotient, 0);
    chk("rst_remainder", out_remainder, 0);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_div_divisor", div_divisor, 0);
    chk("rst_div_start", 32'(div_start), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_no_start", 32'(starts), 0);

    run(32'd100, 32'd7, 32'd14, 32'd2, 3'b000, 35, 1, 1'b0);
    run(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 3'b000, 35, 1, 1'b0);
    run(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 3'b000, 35, 1, 1'b0);
    run(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 3'b000, 35, 1, 1'b0);
    run(32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 3'b000, 35, 1, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 3'b010, 35, 1, 1'b0);
    run(32'd5, 32'd0, 32'h7FFF_FFFF, 32'd5, 3'b001, 1, 0, 1'b0);
    run(-32'sd5, 32'd0, 32'h8000_0000, 32'hFFFF_FFFB, 3'b001, 1, 0, 1'b0);
    run(32'd100, 32'd7, 32'd14, 32'd2, 3'b000, 35, 1, 1'b1);

    tie0 = 1'b1;
    run(32'd100, 32'd7, 32'd0, 32'd0, 3'b100, 42, 1, 1'b0);
    tie0 = 1'b0;

    @(negedge clk);
    in_dividend = 32'd100;
    in_divisor = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_flags", 32'(out_flags), 0);
    chk("midrst_div_dividend", div_dividend, 0);
    ov = 1'b0;
    repeat (50) begin
      @(negedge clk);
      ov |= out_valid;
    end
    chk("midrst_no_out_valid", 32'(ov), 0);
    run(32'd100, 32'd7, 32'd14, 32'd2, 3'b000, 35, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL expose parameter TIMEOUT, default 40, meaning the maximum number of cycles spent in WAIT before the divide is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the signed operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts an operand pair.
REQ-006 SHALL have port in_dividend, input, 32, the two's-complement dividend.
REQ-007 SHALL have port in_divisor, input, 32, the two's-complement divisor.
REQ-008 SHALL have port div_start, output, 1, a one-cycle start pulse to the unsigned divider.
REQ-009 SHALL have ports div_dividend and div_divisor, output, 32 each, the unsigned operand magnitudes.
REQ-010 SHALL have port div_busy, input, 1, the divider busy flag.
REQ-011 SHALL have ports div_quotient and div_remainder, input, 32 each, the unsigned divider results.
REQ-012 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-013 SHALL have port out_ready, input, 1, meaning the result is accepted downstream.
REQ-014 SHALL have ports out_quotient and out_remainder, output, 32 each, the signed results.
REQ-015 SHALL have port out_flags, output, 3, encoded as [0]=div_by_zero, [1]=overflow, [2]=timeout.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; a transfer occurs when in_valid&in_ready, and the FSM moves IDLE->START.
REQ-018 SHALL, on transfer, register the magnitudes onto div_dividend/div_divisor, with |0x80000000| = 0x80000000 unsigned.
REQ-019 SHALL, on transfer, register q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
REQ-020 SHALL, when divisor==0 at transfer, skip the divider and go IDLE->DONE with out_flags[0]=1.
REQ-021 SHALL, for divisor==0, output out_quotient=0x7FFFFFFF for dividend>=0 or 0x80000000 for dividend<0, and out_remainder=dividend.
REQ-022 SHALL assert div_start for exactly the single START cycle, then go START->WAIT.
REQ-023 SHALL, in WAIT, set seen_busy on div_busy=1 and leave on the first cycle with div_busy=0 and seen_busy=1, capturing the results at that edge.
REQ-024 SHALL clear seen_busy at transfer.
REQ-025 SHALL give nominal latency for a 32-cycle divider as: transfer edge T; div_start high in cycle T+1; div_busy high for cycles T+2..T+33; capture at the end of cycle T+34; out_valid=1 from T+35.
REQ-026 SHALL set out_quotient to the negated magnitude if q_neg, else the magnitude; out_remainder likewise by r_neg; truncation is toward zero.
REQ-027 SHALL, when the quotient magnitude > 0x7FFFFFFF and q_neg=0 (only -2^31/-1), saturate out_quotient to 0x7FFFFFFF with out_flags[1]=1.
REQ-028 SHALL, when the WAIT cycle count reaches TIMEOUT, go to DONE with out_quotient=0, out_remainder=0 and out_flags[2]=1.
REQ-029 SHALL hold out_valid, data and flags stable in DONE until out_ready=1; the DONE->IDLE transition occurs on that edge.
REQ-030 SHALL ignore in_valid outside IDLE, and SHALL NOT permit a same-cycle accept on the out transfer edge.
REQ-031 SHALL ignore div_busy/div_quotient/div_remainder outside WAIT.

Reset
REQ-032 SHALL, with rst=1 at a clock edge, enter IDLE from any state, including mid-WAIT, discarding any in-flight operation.
REQ-033 SHALL set reset values in_ready=1 (after the edge), div_start=0, out_valid=0, out_flags=0, out_quotient=0, out_remainder=0, div_dividend=0, div_divisor=0, seen_busy=0, and WAIT counter=0.
REQ-034 SHALL NOT issue a div_start pulse in the reset cycle or the cycle following it.

Verification
REQ-035 SHALL cover: 100 / 7 -> quotient 14, remainder 2, flags 0, out_valid at T+35.
REQ-036 SHALL cover: -100 / 7 -> quotient -14, remainder -2; and 100 / -7 -> quotient -14, remainder 2.
REQ-037 SHALL cover: 0x80000000 / 0xFFFFFFFF -> quotient 0x7FFFFFFF, flags=3'b010; and 5 / 0 -> quotient 0x7FFFFFFF, remainder 5, flags=3'b001, with no div_start pulse.
REQ-038 SHALL cover: out_ready held 0 for 10 cycles -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, and in_ready=1 the next cycle.
REQ-039 SHALL cover: div_busy tied 0 -> out_flags=3'b100 after TIMEOUT cycles in WAIT.
REQ-040 SHALL cover: rst pulsed at T+20 of a divide -> out_valid never asserts, in_ready=1 after the reset edge, and a new divide completes correctly.
